dff_write_arbiter: RTL

//  Round-robin write arbiter and loader for one shared DATA_W-bit D flip-flop register.
//  N_REQ requesters compete to write it; one write is granted per cycle.
//  The block owns the register, reports the last writer, and supports clear and freeze control.
//  It sits between requester FSMs and any logic that consumes the register value.

---
 rtl/dff_arb_pkg.sv | 35 +++
 rtl/dff_write_arbiter_rr_pick.sv | 49 ++++
 rtl/dff_write_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/dff_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dff_arb_pkg
// Description : Shared types, constants and helpers for the round-robin
//               write arbiter of a single shared D flip-flop register.
// Revision    : 1.0 - initial release
// ============================================================================
package dff_arb_pkg;

    // Default configuration: four requesters writing a 4-bit register
    localparam int DEF_N_REQ  = 4;
    localparam int DEF_DATA_W = 4;

    // Largest supported requester count and the index width it needs
    localparam int MAX_REQ    = 8;
    localparam int MAX_IDX_W  = 3;

    // Index width for the default requester count
    localparam int IDX_W      = $clog2(DEF_N_REQ);

    // IDLE: nothing to grant (no request or frozen); ARB: a pick is made
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ARB  = 1'b1
    } arb_state_t;

    // One-hot decode of a requester index, sized for the largest config;
    // callers truncate to their own requester count
    function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dff_write_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns the first asserted
//               request at index ptr, ptr+1, ... wrapping modulo N_REQ.
//               Built as rotate, fixed-priority encode, un-rotate.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import dff_arb_pkg::*;
#(
    parameter  int N_REQ   = DEF_N_REQ,
    localparam int c_idx_w = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0]   req,
    input  logic [c_idx_w-1:0] ptr,
    output logic               valid,
    output logic [c_idx_w-1:0] idx
);

    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [c_idx_w-1:0] w_off;
    logic [c_idx_w:0]   w_sum;

    // Rotate so the pointer position lands at bit 0: w_rot[i] = req[(i+ptr) mod N]
    assign w_dbl = {req, req};
    assign w_rot = N_REQ'(w_dbl >> ptr);

    // Fixed-priority encode of the rotated vector, lowest index wins
    always_comb begin
        w_off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = c_idx_w'(i);
            end
        end
    end

    // Un-rotate: add the pointer back and wrap modulo N_REQ
    assign w_sum = {1'b0, w_off} + {1'b0, ptr};
    assign idx   = (w_sum >= (c_idx_w + 1)'(N_REQ))
                 ? c_idx_w'(w_sum - (c_idx_w + 1)'(N_REQ))
                 : w_sum[c_idx_w-1:0];

    assign valid = |req;

endmodule
`default_nettype wire

// File: rtl/dff_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dff_write_arbiter
// Description : Round-robin write arbiter and loader for one shared
//               DATA_W-bit register. One write is granted per cycle; the
//               block reports the last writer and supports clear and freeze.
//               Priority of controls: Rst > Clr > Hold > write.
// Revision    : 1.0 - initial release
// ============================================================================
module dff_write_arbiter
    import dff_arb_pkg::*;
#(
    parameter  int N_REQ   = DEF_N_REQ,
    parameter  int DATA_W  = DEF_DATA_W,
    localparam int c_idx_w = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [N_REQ-1:0]          Req,
    input  logic [N_REQ*DATA_W-1:0]   Req_data,
    input  logic                      Clr,
    input  logic                      Hold,
    output logic [N_REQ-1:0]          Gnt,
    output logic [DATA_W-1:0]         Q,
    output logic                      Q_valid,
    output logic [c_idx_w-1:0]        Q_src,
    output logic                      Busy
);

    arb_state_t          r_state;
    arb_state_t          w_state_next;
    logic [c_idx_w-1:0]  r_ptr;
    logic [c_idx_w-1:0]  w_ptr_next;
    logic                w_pick_valid;
    logic [c_idx_w-1:0]  w_pick_idx;
    logic                w_write;
    logic [DATA_W-1:0]   w_data_arr [N_REQ];

    logic [N_REQ-1:0]    r_gnt;
    logic [DATA_W-1:0]   r_q;
    logic                r_q_valid;
    logic [c_idx_w-1:0]  r_q_src;

    // Split the flat data bus into one lane per requester
    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        assign w_data_arr[i] = Req_data[i*DATA_W +: DATA_W];
    end

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req   (Req),
        .ptr   (r_ptr),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    // Pointer moves to the slot just after the winner so it loses priority next time
    assign w_ptr_next = (w_pick_idx == c_idx_w'(N_REQ - 1)) ? '0 : w_pick_idx + 1'b1;

    assign Busy = (|Req) && !Hold;

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a write happens only when arbitrating and not cleared
    always_comb begin
        w_state_next = r_state;
        w_write      = 1'b0;
        case (r_state)
            IDLE: begin
                if ((|Req) && !Hold) begin
                    w_state_next = ARB;
                end
            end
            ARB: begin
                if ((Req == '0) || Hold) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        if ((w_state_next == ARB) && w_pick_valid && !Clr) begin
            w_write = 1'b1;
        end
    end

    // Register contents, valid flag, last writer, grant pulse and pointer
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_gnt     <= '0;
            r_q       <= '0;
            r_q_valid <= 1'b0;
            r_q_src   <= '0;
            r_ptr     <= '0;
        end else if (Clr) begin
            // Clear beats a concurrent write; last-writer index is kept
            r_gnt     <= '0;
            r_q       <= '0;
            r_q_valid <= 1'b0;
        end else if (Hold) begin
            r_gnt     <= '0;
        end else if (w_write) begin
            r_gnt     <= N_REQ'(onehot(MAX_IDX_W'(w_pick_idx)));
            r_q       <= w_data_arr[w_pick_idx];
            r_q_valid <= 1'b1;
            r_q_src   <= w_pick_idx;
            r_ptr     <= w_ptr_next;
        end else begin
            r_gnt     <= '0;
        end
    end

    assign Gnt     = r_gnt;
    assign Q       = r_q;
    assign Q_valid = r_q_valid;
    assign Q_src   = r_q_src;

endmodule
`default_nettype wire
